// File: rtl/ps2_codes_pkg.sv
// Purpose : PS/2 set-2 scan-code constants, prefix-tracker states and the
//           digit decode helper shared by the numeric-entry block.
// Ports   : none (package).
package ps2_codes_pkg;

  // Prefix and control bytes.
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  // Main-block digit keys (not the keypad).
  localparam logic [7:0] SC_D0 = 8'h45;
  localparam logic [7:0] SC_D1 = 8'h16;
  localparam logic [7:0] SC_D2 = 8'h1E;
  localparam logic [7:0] SC_D3 = 8'h26;
  localparam logic [7:0] SC_D4 = 8'h25;
  localparam logic [7:0] SC_D5 = 8'h2E;
  localparam logic [7:0] SC_D6 = 8'h36;
  localparam logic [7:0] SC_D7 = 8'h3D;
  localparam logic [7:0] SC_D8 = 8'h3E;
  localparam logic [7:0] SC_D9 = 8'h46;

  // Where we are inside a multi-byte scan sequence.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // next byte starts a new sequence
    ST_BRK     = 2'd1,  // saw F0: next byte is a release code
    ST_EXT     = 2'd2,  // saw E0: extended key follows
    ST_EXT_BRK = 2'd3   // saw E0 F0: next byte is an extended release
  } prefix_state_t;

  // Packed so it reads as {is_digit, digit[3:0]}.
  typedef struct packed {
    logic       is_digit;
    logic [3:0] digit;
  } digit_t;

  function automatic digit_t scan_to_digit(input logic [7:0] code);
    digit_t r;
    r.is_digit = 1'b1;
    r.digit    = 4'd0;
    case (code)
      SC_D0:   r.digit = 4'd0;
      SC_D1:   r.digit = 4'd1;
      SC_D2:   r.digit = 4'd2;
      SC_D3:   r.digit = 4'd3;
      SC_D4:   r.digit = 4'd4;
      SC_D5:   r.digit = 4'd5;
      SC_D6:   r.digit = 4'd6;
      SC_D7:   r.digit = 4'd7;
      SC_D8:   r.digit = 4'd8;
      SC_D9:   r.digit = 4'd9;
      default: r.is_digit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_prefix_fsm.sv
// Purpose : strips F0 / E0 / E0 F0 prefixes from the PS/2 byte stream and
//           flags plain (non-extended) make codes.
// Latency : combinational make_valid/make_code in the strobe cycle; prefix
//           state updates on that same edge. No backpressure: every strobe
//           is consumed.
// Ports   : clk, rst (sync, active-low); scan_code/scan_valid in;
//           make_valid/make_code out.
module ps2_prefix_fsm
  import ps2_codes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic       make_valid,
  output logic [7:0] make_code
);

  prefix_state_t state_q;
  prefix_state_t state_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    make_valid = 1'b0;
    make_code  = scan_code;
    if (scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_code == SC_BREAK) begin
            state_d = ST_BRK;
          end else if (scan_code == SC_EXT) begin
            state_d = ST_EXT;
          end else begin
            make_valid = 1'b1;
          end
        end
        // Release code of a plain key: nothing to do on key-up.
        ST_BRK: state_d = ST_IDLE;
        // Extended keys (arrows, keypad Enter, ...) are never interpreted.
        ST_EXT: begin
          if (scan_code == SC_BREAK) begin
            state_d = ST_EXT_BRK;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_EXT_BRK: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ps2_numeric_entry.sv
// Purpose : decimal number entry from a PS/2 keyboard with backspace, Esc,
//           Enter-to-commit, range check, plus two toggle flags.
// Latency : one cycle; every output is registered on the edge that samples
//           scan_valid. No backpressure: one byte per strobe, always accepted.
// Ports   : clk, rst (sync, active-low); scan_code/scan_valid in;
//           value/value_valid, digit_count, pres_flag, ign_flag, err out.
module ps2_numeric_entry
  import ps2_codes_pkg::*;
#(
  parameter int         NUM_DIGITS = 2,
  parameter int         VAL_W      = 7,
  parameter int         MAX_VALUE  = 99,
  parameter logic [7:0] KEY_PRES   = 8'h4D,
  parameter logic [7:0] KEY_IGN    = 8'h43
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      scan_code,
  input  logic                            scan_valid,
  output logic [VAL_W-1:0]                value,
  output logic                            value_valid,
  output logic [$clog2(NUM_DIGITS+1)-1:0] digit_count,
  output logic                            pres_flag,
  output logic                            ign_flag,
  output logic                            err
);

  localparam int              CNT_W   = $clog2(NUM_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [31:0]      MAX_U   = 32'(MAX_VALUE);

  logic       make_valid;
  logic [7:0] make_code;
  digit_t     dig;

  ps2_prefix_fsm u_prefix (
    .clk        (clk),
    .rst        (rst),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .make_valid (make_valid),
    .make_code  (make_code)
  );

  assign dig = scan_to_digit(make_code);

  logic [VAL_W-1:0] acc_q;
  logic [VAL_W-1:0] acc_d;
  logic [VAL_W-1:0] acc_push;
  logic [VAL_W-1:0] acc_pop;
  logic [CNT_W-1:0] count_d;
  logic [VAL_W-1:0] value_d;
  logic             value_valid_d;
  logic             err_d;
  logic             pres_d;
  logic             ign_d;

  // acc*10 + d built from shifts at four bits of headroom, then truncated.
  assign acc_push = VAL_W'(({4'b0000, acc_q} << 3) + ({4'b0000, acc_q} << 1)
                           + {{VAL_W{1'b0}}, dig.digit});
  assign acc_pop  = acc_q / VAL_W'(10);

  always_comb begin
    acc_d         = acc_q;
    count_d       = digit_count;
    value_d       = value;
    value_valid_d = 1'b0;
    err_d         = 1'b0;
    pres_d        = pres_flag;
    ign_d         = ign_flag;
    if (make_valid) begin
      if (dig.is_digit) begin
        if (digit_count < CNT_MAX) begin
          acc_d   = acc_push;
          count_d = digit_count + CNT_ONE;
        end else begin
          err_d = 1'b1;
        end
      end else if (make_code == SC_BKSP) begin
        // An empty entry simply ignores backspace.
        if (digit_count != '0) begin
          acc_d   = acc_pop;
          count_d = digit_count - CNT_ONE;
        end
      end else if (make_code == SC_ESC) begin
        acc_d   = '0;
        count_d = '0;
      end else if (make_code == SC_ENTER) begin
        if (digit_count != '0) begin
          if (32'(acc_q) <= MAX_U) begin
            value_d       = acc_q;
            value_valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        // The entry is consumed whether it committed, was rejected or was empty.
        acc_d   = '0;
        count_d = '0;
      end else if (make_code == KEY_PRES) begin
        pres_d = ~pres_flag;
      end else if (make_code == KEY_IGN) begin
        ign_d = ~ign_flag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q       <= '0;
      digit_count <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      err         <= 1'b0;
      pres_flag   <= 1'b0;
      ign_flag    <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      digit_count <= count_d;
      value       <= value_d;
      value_valid <= value_valid_d;
      err         <= err_d;
      pres_flag   <= pres_d;
      ign_flag    <= ign_d;
    end
  end

endmodule

// File: tb/tb_ps2_numeric_entry.sv
// Purpose : self-checking bench for ps2_numeric_entry: directed scenarios
//           followed by random byte streams, checked against a digit-list
//           model through an event scoreboard.
// Ports   : none (top-level bench).
module tb_ps2_numeric_entry;

  localparam int ND     = 2;
  localparam int VW     = 7;
  localparam int TB_MAX = 50;

  logic       clk;
  logic       rst;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic [VW-1:0] value;
  logic       value_valid;
  logic [1:0] digit_count;
  logic       pres_flag;
  logic       ign_flag;
  logic       err;

  ps2_numeric_entry #(
    .NUM_DIGITS (ND),
    .VAL_W      (VW),
    .MAX_VALUE  (TB_MAX),
    .KEY_PRES   (8'h4D),
    .KEY_IGN    (8'h43)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .scan_code   (scan_code),
    .scan_valid  (scan_valid),
    .value       (value),
    .value_valid (value_valid),
    .digit_count (digit_count),
    .pres_flag   (pres_flag),
    .ign_flag    (ign_flag),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit is_err;
    int val;
  } ev_t;

  ev_t exp_q[$];
  int  digs[$];        // pending digits, most significant first
  bit  skip_next;      // previous byte was a break prefix
  bit  after_ext;      // previous byte was the extended prefix
  bit  m_pres, m_ign;
  int  m_val;
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                   8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  function automatic int digit_of(input logic [7:0] b);
    for (int i = 0; i < 10; i++) if (digit_codes[i] == b) return i;
    return -1;
  endfunction

  function automatic int entry_number();
    int n = 0;
    foreach (digs[i]) n = n * 10 + digs[i];
    return n;
  endfunction

  task automatic model_reset();
    digs.delete();
    exp_q.delete();
    skip_next = 0;
    after_ext = 0;
    m_pres = 0;
    m_ign = 0;
    m_val = 0;
  endtask

  task automatic model_make(input logic [7:0] b);
    int d;
    ev_t e;
    d = digit_of(b);
    if (d >= 0) begin
      if (digs.size() < ND) digs.push_back(d);
      else begin e.is_err = 1; e.val = m_val; exp_q.push_back(e); end
    end else if (b == 8'h66) begin
      if (digs.size() > 0) void'(digs.pop_back());
    end else if (b == 8'h76) begin
      digs.delete();
    end else if (b == 8'h5A) begin
      if (digs.size() > 0) begin
        if (entry_number() <= TB_MAX) begin
          m_val = entry_number();
          e.is_err = 0;
        end else begin
          e.is_err = 1;
        end
        e.val = m_val;
        exp_q.push_back(e);
      end
      digs.delete();
    end else if (b == 8'h4D) begin
      m_pres = !m_pres;
    end else if (b == 8'h43) begin
      m_ign = !m_ign;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (skip_next) begin
      skip_next = 0;
    end else if (after_ext) begin
      after_ext = 0;
      if (b == 8'hF0) skip_next = 1;
    end else if (b == 8'hF0) begin
      skip_next = 1;
    end else if (b == 8'hE0) begin
      after_ext = 1;
    end else begin
      model_make(b);
    end
  endtask

  // ---------------- monitor ----------------
  bit mon_en = 0;

  always @(negedge clk) begin
    ev_t e;
    if (mon_en && rst === 1'b1 && (value_valid === 1'b1 || err === 1'b1)) begin
      if (exp_q.size() == 0) begin
        chk("event_expected", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind", {30'd0, value_valid, err}, e.is_err ? 32'd1 : 32'd2);
        chk("event_value", value, e.val);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] b);
    scan_code  = b;
    scan_valid = 1'b1;
    model_byte(b);
    @(posedge clk); #1;
    scan_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Lets the last response reach the monitor, then compares held state.
  task automatic check_state(input string tag);
    @(negedge clk);
    @(posedge clk); #2;
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_digit_count"}, digit_count, digs.size());
    chk({tag, "_value"}, value, m_val);
    chk({tag, "_pres"}, pres_flag, m_pres);
    chk({tag, "_ign"}, ign_flag, m_ign);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [7:0] b;
    rst = 1'b1;
    scan_code = 8'h00;
    scan_valid = 1'b0;
    model_reset();
    @(posedge clk); #1;

    // Reset held for two edges while a digit is strobed.
    rst = 1'b0;
    scan_code = 8'h16;
    scan_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_value", value, 0);
    chk("rst_value_valid", value_valid, 0);
    chk("rst_digit_count", digit_count, 0);
    chk("rst_pres", pres_flag, 0);
    chk("rst_ign", ign_flag, 0);
    chk("rst_err", err, 0);
    scan_valid = 1'b0;
    rst = 1'b1;
    mon_en = 1;
    idle(1);
    chk("post_rst_digit_count", digit_count, 0);

    // 3, 5 with releases in between, then Enter.
    send(8'h26); send(8'hF0); send(8'h26);
    send(8'h2E); send(8'hF0); send(8'h2E);
    chk("two_digits_pending", digit_count, 2);
    send(8'h5A);
    check_state("entry");
    chk("entry_value_35", value, 35);

    // Third digit overflows, backspace drops the 9, Enter commits 8.
    send(8'h3E); send(8'h46); send(8'h16);
    check_state("overflow");
    chk("overflow_count_2", digit_count, 2);
    send(8'h66); send(8'h5A);
    check_state("bksp");
    chk("bksp_value_8", value, 8);

    // Extended and release prefixes.
    send(8'hE0); send(8'h5A); send(8'hE0); send(8'hF0); send(8'h5A);
    send(8'hF0); send(8'h4D);
    check_state("prefix");
    chk("prefix_pres_0", pres_flag, 0);
    send(8'h4D); send(8'h43);
    check_state("toggle");
    chk("toggle_pres_1", pres_flag, 1);
    chk("toggle_ign_1", ign_flag, 1);
    send(8'h4D);
    check_state("toggle2");
    chk("toggle2_pres_0", pres_flag, 0);

    // 60 > limit is rejected; empty Enter is silent; 50 is on the limit.
    send(8'h36); send(8'h45); send(8'h5A);
    check_state("reject");
    chk("reject_value_8", value, 8);
    send(8'h5A);
    check_state("empty_enter");
    send(8'h2E); send(8'h45); send(8'h5A);
    check_state("limit");
    chk("limit_value_50", value, 50);
    send(8'h16); send(8'h76); send(8'h5A);
    check_state("esc");

    // Reset in the middle of an entry.
    send(8'h16); send(8'h1E);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    model_reset();
    send(8'h5A);
    check_state("mid_reset");
    chk("mid_reset_value_0", value, 0);

    // Random byte streams.
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      b = digit_codes[$urandom_range(0, 9)];
      else if (r < 55) b = 8'hF0;
      else if (r < 60) b = 8'hE0;
      else if (r < 72) b = 8'h5A;
      else if (r < 78) b = 8'h66;
      else if (r < 82) b = 8'h76;
      else if (r < 87) b = 8'h4D;
      else if (r < 91) b = 8'h43;
      else             b = 8'($urandom_range(0, 255));
      send(b);
      idle($urandom_range(0, 2));
      if (n % 100 == 99) check_state("random");
    end
    check_state("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
